// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg: shared ALU interface constants (condition codes, NZCV bit indices)
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// ============================================================================
// cond_check: combinational condition-code evaluation against NZCV flags
// Rev 1.0
// ============================================================================
`default_nettype none

module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = nzcv[NZCV_N];
  assign w_z = nzcv[NZCV_Z];
  assign w_c = nzcv[NZCV_C];
  assign w_v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_commit.sv
// ============================================================================
// alu_result_commit: conditional NZCV commit plus register writeback FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_result_commit
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_z,
  input  logic                     in_n,
  input  logic                     in_c,
  input  logic                     in_v,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic                     in_set_flags,
  input  logic [3:0]               in_cond,
  output logic                     rf_we,
  input  logic                     rf_ready,
  output logic [REG_AW-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [3:0]               nzcv,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [3:0]        r_nzcv;
  logic [7:0]        r_drop;

  logic w_pass;
  logic w_accept;
  logic w_push;
  logic w_pop;

  cond_check u_cond_check (
    .cond (in_cond),
    .nzcv (r_nzcv),
    .pass (w_pass)
  );

  // Ready depends only on occupancy, so rf_ready never reaches in_ready.
  assign in_ready = (r_count != CW'(DEPTH));
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_pass & (in_rd != '0);
  assign rf_we    = (r_count != '0);
  assign w_pop    = rf_we & rf_ready;

  assign rf_addr    = r_mem_addr[r_rd_ptr];
  assign rf_wdata   = r_mem_data[r_rd_ptr];
  assign nzcv       = r_nzcv;
  assign fifo_count = r_count;
  assign drop_cnt   = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_nzcv   <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept & w_pass & in_set_flags) r_nzcv <= {in_n, in_z, in_c, in_v};
      if (w_accept & ~w_pass & (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // Storage carries no reset; validity is tracked solely by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= in_rd;
      r_mem_data[r_wr_ptr] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_commit.sv
// ============================================================================
// tb_alu_result_commit: scoreboard bench with behavioural flag/FIFO model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_commit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_z, in_n, in_c, in_v;
  logic [AW-1:0] in_rd;
  logic          in_set_flags;
  logic [3:0]    in_cond;
  logic          rf_we;
  logic          rf_ready;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [3:0]    nzcv;
  logic [2:0]    fifo_count;
  logic [7:0]    drop_cnt;

  alu_result_commit #(.DATA_W(DW), .REG_AW(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_z         (in_z),
    .in_n         (in_n),
    .in_c         (in_c),
    .in_v         (in_v),
    .in_rd        (in_rd),
    .in_set_flags (in_set_flags),
    .in_cond      (in_cond),
    .rf_we        (rf_we),
    .rf_ready     (rf_ready),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata),
    .nzcv         (nzcv),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [3:0] m_nzcv = 4'd0;
  int         m_drop = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs: even code is the base test, odd inverts it.
  function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'd15) return 1'b0;
    return base ^ c[0];
  endfunction

  // Monitor/scoreboard: compare state, retire pops, then apply the accepted result.
  always @(negedge clk) begin
    if (!rst) begin
      bit m_ready;
      wr_t e;
      m_ready = (exp_q.size() < DEPTH);
      check("fifo_count", fifo_count, exp_q.size());
      check("rf_we", rf_we, exp_q.size() != 0);
      check("in_ready", in_ready, m_ready);
      check("nzcv", nzcv, m_nzcv);
      check("drop_cnt", drop_cnt, m_drop);
      if (rf_we && rf_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rf_addr", rf_addr, e.addr);
          check("rf_wdata", rf_wdata, e.data);
        end
      end
      if (in_valid && m_ready) begin
        if (model_pass(in_cond, m_nzcv)) begin
          if (in_rd != 0) begin
            e.addr = in_rd;
            e.data = in_data;
            exp_q.push_back(e);
          end
          if (in_set_flags) m_nzcv = {in_n, in_z, in_c, in_v};
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic [4:0] rd, input logic [3:0] f,
                       input logic sf, input logic [3:0] c);
    in_valid = 1'b1; in_data = d; in_rd = rd;
    {in_n, in_z, in_c, in_v} = f;
    in_set_flags = sf; in_cond = c;
  endtask

  // Called at posedge+1; holds the result until it is accepted.
  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic [3:0] f,
                      input logic sf, input logic [3:0] c);
    int t;
    t = 0;
    drive(d, rd, f, sf, c);
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 1, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rd = '0;
    {in_n, in_z, in_c, in_v} = 4'd0; in_set_flags = 1'b0; in_cond = 4'd14;
    rf_ready = 1'b0;
    cycles(2);
    check("reset_rf_we", rf_we, 0);
    check("reset_count", fifo_count, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_nzcv", nzcv, 0);
    rst = 1'b0;
    cycles(1);

    // Basic push with latency check.
    rf_ready = 1'b0;
    send(32'h5, 5'd3, 4'b0000, 1'b1, 4'd14);
    check("lat_rf_we", rf_we, 1);
    check("lat_rf_addr", rf_addr, 3);
    check("lat_rf_wdata", rf_wdata, 5);
    rf_ready = 1'b1;
    cycles(2);
    check("drained_count", fifo_count, 0);

    // Flags-only update, then EQ pass, then NE fail.
    send(32'h0, 5'd0, 4'b0100, 1'b1, 4'd14);
    send(32'hAA, 5'd4, 4'b0000, 1'b0, 4'd0);
    check("eq_nzcv", nzcv, 4'b0100);
    send(32'hBB, 5'd5, 4'b0000, 1'b0, 4'd1);
    cycles(2);
    check("ne_drop", drop_cnt, 1);

    // Fill while stalled, hold a fifth, then release.
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'h100 + i, 5'(i), 4'd0, 1'b0, 4'd14);
    drive(32'h105, 5'd5, 4'd0, 1'b0, 4'd14);
    repeat (3) begin
      cycles(1);
      check("full_in_ready", in_ready, 0);
    end
    rf_ready = 1'b1;
    send(32'h105, 5'd5, 4'd0, 1'b0, 4'd14);
    cycles(6);
    check("full_drained", fifo_count, 0);

    // Steady push/pop at occupancy two across pointer wrap.
    rf_ready = 1'b0;
    send(32'h200, 5'd6, 4'd0, 1'b0, 4'd14);
    send(32'h201, 5'd7, 4'd0, 1'b0, 4'd14);
    rf_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'h300 + i, 5'((i % 31) + 1), 4'd0, 1'b0, 4'd14);
      check("steady_count", fifo_count, 2);
    end
    cycles(4);

    // Saturating drop counter.
    for (int i = 0; i < 300; i++) send($urandom, 5'($urandom_range(1, 31)), 4'($urandom), 1'b1, 4'd15);
    cycles(2);
    check("sat_drop", drop_cnt, 255);
    check("sat_count", fifo_count, 0);
    check("sat_nzcv", nzcv, 4'b0100);

    // Asynchronous reset with three entries queued.
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h400 + i, 5'(i + 8), 4'd0, 1'b1, 4'd14);
    check("pre_rst_count", fifo_count, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_rf_we", rf_we, 0);
    check("arst_count", fifo_count, 0);
    check("arst_nzcv", nzcv, 0);
    check("arst_drop", drop_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete(); m_nzcv = 4'd0; m_drop = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycles(1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = $urandom;
      in_rd = 5'($urandom_range(0, 7));
      {in_n, in_z, in_c, in_v} = 4'($urandom);
      in_set_flags = 1'($urandom);
      in_cond = 4'($urandom);
      rf_ready = ($urandom_range(0, 9) < 6);
      cycles(1);
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    cycles(8);
    check("final_count", fifo_count, 0);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
